// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit and memory.
// The fetch unit drives request and address; memory returns ready and data.
interface fetch_unit_if #(
   parameter int ADDRESS_LEN     = 32,
   parameter int INSTRUCTION_LEN = 32
);
   logic                       imem_req;
   logic [ADDRESS_LEN-1:0]     imem_addr;
   logic                       imem_ready;
   logic [INSTRUCTION_LEN-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, one-entry skid buffer for decode
// stalls, and a drain state that discards the response to a redirected fetch.
module fetch_unit #(
   parameter int ADDRESS_LEN     = 32,
   parameter int INSTRUCTION_LEN = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       freeze,
   input  logic                       branch_taken,
   input  logic [ADDRESS_LEN-1:0]     branch_addr,
   fetch_unit_if.master               imem,
   output logic [ADDRESS_LEN-1:0]     PC,
   output logic [INSTRUCTION_LEN-1:0] instruction,
   output logic                       valid
);

   typedef enum logic [1:0] {
      FETCH,
      BUFFERED,
      DRAIN
   } state_t;

   state_t                     state, state_n;
   logic [ADDRESS_LEN-1:0]     pc, pc_n;
   logic [ADDRESS_LEN-1:0]     req_addr, req_addr_n;
   logic [ADDRESS_LEN-1:0]     skid_pc, skid_pc_n;
   logic [INSTRUCTION_LEN-1:0] skid_ins, skid_ins_n;
   logic [ADDRESS_LEN-1:0]     id_pc_n;
   logic [INSTRUCTION_LEN-1:0] id_ins_n;
   logic                       id_valid_n;
   logic [ADDRESS_LEN-1:0]     seq_addr;
   logic                       ready;

   assign ready          = imem.imem_ready;
   assign seq_addr       = req_addr + ADDRESS_LEN'(4);
   assign imem.imem_addr = req_addr;
   // Gate with rst so memory sees the request drop in the same cycle.
   assign imem.imem_req  = !rst && (state != BUFFERED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= '0;
         req_addr    <= '0;
         skid_pc     <= '0;
         skid_ins    <= '0;
         PC          <= '0;
         instruction <= '0;
         valid       <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         req_addr    <= req_addr_n;
         skid_pc     <= skid_pc_n;
         skid_ins    <= skid_ins_n;
         PC          <= id_pc_n;
         instruction <= id_ins_n;
         valid       <= id_valid_n;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      req_addr_n = req_addr;
      skid_pc_n  = skid_pc;
      skid_ins_n = skid_ins;
      id_pc_n    = PC;
      id_ins_n   = instruction;
      id_valid_n = valid;

      if (branch_taken) begin
         pc_n       = branch_addr;
         skid_pc_n  = '0;
         skid_ins_n = '0;
         id_pc_n    = '0;
         id_ins_n   = '0;
         id_valid_n = 1'b0;
         // An in-flight fetch must complete before the new target can issue.
         if (ready || state == BUFFERED) begin
            req_addr_n = branch_addr;
            state_n    = FETCH;
         end else begin
            state_n    = DRAIN;
         end
      end else begin
         unique case (state)
            FETCH: begin
               if (freeze) begin
                  if (ready) begin
                     skid_pc_n  = seq_addr;
                     skid_ins_n = imem.imem_rdata;
                     pc_n       = seq_addr;
                     state_n    = BUFFERED;
                  end
               end else if (ready) begin
                  id_pc_n    = seq_addr;
                  id_ins_n   = imem.imem_rdata;
                  id_valid_n = 1'b1;
                  pc_n       = seq_addr;
                  req_addr_n = seq_addr;
               end else begin
                  id_ins_n   = '0;
                  id_valid_n = 1'b0;
               end
            end
            BUFFERED: begin
               if (!freeze) begin
                  id_pc_n    = skid_pc;
                  id_ins_n   = skid_ins;
                  id_valid_n = 1'b1;
                  req_addr_n = pc;
                  state_n    = FETCH;
               end
            end
            DRAIN: begin
               id_ins_n   = '0;
               id_valid_n = 1'b0;
               if (ready) begin
                  req_addr_n = pc;
                  state_n    = FETCH;
               end
            end
            default: state_n = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory returns rdata = address, expected
// IF/ID contents are queued as fetches are driven and popped on delivery.
module tb_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_addr = '0;
   logic        ready = 1'b0;
   logic [31:0] PC;
   logic [31:0] instruction;
   logic        valid;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   fetch_unit_if #(.ADDRESS_LEN(32), .INSTRUCTION_LEN(32)) mem ();

   assign mem.imem_ready = ready;
   assign mem.imem_rdata = ready ? mem.imem_addr : 32'hdeadbeef;

   fetch_unit #(.ADDRESS_LEN(32), .INSTRUCTION_LEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem         (mem.master),
      .PC           (PC),
      .instruction  (instruction),
      .valid        (valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] p, input logic [31:0] i);
      exp_t e;
      e.pc  = p;
      e.ins = i;
      sb.push_back(e);
   endtask

   // One clock: drive inputs, pass the edge, then retire any delivered fetch.
   task automatic cycle(input logic f, input logic br, input logic rdy,
                        input logic [31:0] ba);
      exp_t e;
      freeze       = f;
      branch_taken = br;
      ready        = rdy;
      branch_addr  = ba;
      @(posedge clk);
      #1;
      if (!f && !br && valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", PC, 32'hffffffff);
         end else begin
            e = sb.pop_front();
            check("if_pc", PC, e.pc);
            check("if_ins", instruction, e.ins);
         end
      end
   endtask

   initial begin
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_req", {31'd0, mem.imem_req}, 32'd0);
      check("rst_addr", mem.imem_addr, 32'd0);
      check("rst_pc", PC, 32'd0);
      check("rst_ins", instruction, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      rst = 1'b0;
      #1;
      check("first_req", {31'd0, mem.imem_req}, 32'd1);
      check("first_addr", mem.imem_addr, 32'd0);

      // Zero-wait streaming.
      for (int a = 0; a < 16; a += 4) begin
         push(a + 4, a);
         cycle(1'b0, 1'b0, 1'b1, '0);
      end
      check("stream_addr", mem.imem_addr, 32'h10);

      // Stall lands on the returning fetch of 0x10.
      cycle(1'b1, 1'b0, 1'b1, '0);
      check("buf_req", {31'd0, mem.imem_req}, 32'd0);
      check("buf_hold_pc", PC, 32'h10);
      check("buf_hold_ins", instruction, 32'hc);
      cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      check("buf_req2", {31'd0, mem.imem_req}, 32'd0);
      push(32'h14, 32'h10);
      cycle(1'b0, 1'b0, 1'b0, '0);
      check("rel_addr", mem.imem_addr, 32'h14);

      // Memory ready every third cycle.
      for (int a = 32'h14; a < 32'h20; a += 4) begin
         cycle(1'b0, 1'b0, 1'b0, '0);
         check("wait_valid", {31'd0, valid}, 32'd0);
         check("wait_addr", mem.imem_addr, a);
         cycle(1'b0, 1'b0, 1'b0, '0);
         check("wait_addr", mem.imem_addr, a);
         push(a + 4, a);
         cycle(1'b0, 1'b0, 1'b1, '0);
      end

      // Redirect while 0x20 is outstanding.
      cycle(1'b0, 1'b1, 1'b0, 32'h100);
      check("drain_valid", {31'd0, valid}, 32'd0);
      check("drain_addr", mem.imem_addr, 32'h20);
      check("drain_req", {31'd0, mem.imem_req}, 32'd1);
      cycle(1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, 1'b1, '0);
      check("drain_discard", {31'd0, valid}, 32'd0);
      check("drain_next", mem.imem_addr, 32'h100);
      push(32'h104, 32'h100);
      cycle(1'b0, 1'b0, 1'b1, '0);

      // Branch with freeze while buffered.
      cycle(1'b1, 1'b0, 1'b1, '0);
      check("buf2_req", {31'd0, mem.imem_req}, 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 32'h100);
      check("bbr_valid", {31'd0, valid}, 32'd0);
      check("bbr_addr", mem.imem_addr, 32'h100);
      check("bbr_req", {31'd0, mem.imem_req}, 32'd1);
      push(32'h104, 32'h100);
      cycle(1'b0, 1'b0, 1'b1, '0);

      // Back-to-back redirects while draining: last target wins.
      cycle(1'b0, 1'b1, 1'b0, 32'h300);
      cycle(1'b0, 1'b1, 1'b0, 32'h400);
      cycle(1'b0, 1'b0, 1'b1, '0);
      check("last_target", mem.imem_addr, 32'h400);
      push(32'h404, 32'h400);
      cycle(1'b0, 1'b0, 1'b1, '0);

      // Address wrap at the top of memory.
      cycle(1'b0, 1'b1, 1'b1, 32'hfffffffc);
      check("wrap_addr0", mem.imem_addr, 32'hfffffffc);
      push(32'h0, 32'hfffffffc);
      cycle(1'b0, 1'b0, 1'b1, '0);
      check("wrap_pc", PC, 32'h0);
      check("wrap_next", mem.imem_addr, 32'h0);
      push(32'h4, 32'h0);
      cycle(1'b0, 1'b0, 1'b1, '0);

      // Reset asserted in the middle of a wait.
      ready = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mrst_req", {31'd0, mem.imem_req}, 32'd0);
      check("mrst_addr", mem.imem_addr, 32'd0);
      check("mrst_pc", PC, 32'd0);
      check("mrst_ins", instruction, 32'd0);
      check("mrst_valid", {31'd0, valid}, 32'd0);
      check("sb_left", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
